// File: rtl/result_uart_tx.sv
// result_uart_tx
//   Sends the CPU's 16-bit final result over a UART line once the CPU halts.
//   A rising edge on halted captures result into a shadow register. The block
//   then sends two back-to-back 8N1 frames: the high byte first, then the low
//   byte. Each bit lasts CLKS_PER_BIT clocks.
//
//   Ports
//     clk     system clock; all state changes on its rising edge
//     reset   asynchronous, active-low reset
//     halted  CPU halt flag; a rising edge requests a transmission
//     result  CPU final result, sampled on the halted rising edge
//     tx      UART serial line, idle high, driven from a flop
//     busy    high while the frame pair is being sent
//     done    high after both bytes are sent, until halted is seen low
//
//   state | meaning
//   IDLE  | line idle (tx=1), waiting for a halted rising edge
//   START | sending the start bit (0) of the current byte
//   DATA  | sending data bit bit_idx of the current byte, LSB first
//   STOP  | sending the stop bit (1); then the next byte or back to IDLE
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halted,
    input  logic [15:0] result,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] BAUD_TC = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic [15:0] baud_cnt, baud_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        byte_sel, byte_sel_n;
    logic [15:0] shadow, shadow_n;
    logic        halted_prev;
    logic        tx_n, busy_n, done_n;

    logic        trigger;
    logic        baud_tc;
    logic [7:0]  cur_byte;
    logic [2:0]  nxt_idx;

    assign trigger  = halted & ~halted_prev & ~busy;
    assign baud_tc  = (baud_cnt == BAUD_TC);
    assign cur_byte = byte_sel ? shadow[7:0] : shadow[15:8];
    assign nxt_idx  = bit_idx + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            byte_sel    <= 1'b0;
            shadow      <= '0;
            halted_prev <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            baud_cnt    <= baud_cnt_n;
            bit_idx     <= bit_idx_n;
            byte_sel    <= byte_sel_n;
            shadow      <= shadow_n;
            halted_prev <= halted;
            tx          <= tx_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    // Next-state and next-output logic. The tx, busy and done outputs are the
    // registered versions of tx_n, busy_n and done_n, so tx is glitch-free.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        byte_sel_n = byte_sel;
        shadow_n   = shadow;
        tx_n       = tx;
        busy_n     = busy;
        done_n     = done;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (trigger) begin
                    state_n    = START;
                    shadow_n   = result;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    byte_sel_n = 1'b0;
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    tx_n       = 1'b0;
                end else if (!halted) begin
                    done_n = 1'b0;
                end
            end

            START: begin
                if (baud_tc) begin
                    state_n    = DATA;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    tx_n       = cur_byte[0];
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end

            DATA: begin
                if (baud_tc) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = nxt_idx;
                        tx_n      = cur_byte[nxt_idx];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end

            STOP: begin
                if (baud_tc) begin
                    baud_cnt_n = '0;
                    if (!byte_sel) begin
                        // The low byte's start bit follows with no idle gap.
                        state_n    = START;
                        byte_sel_n = 1'b1;
                        tx_n       = 1'b0;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule
